// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch stage and the memory stage. Data
// accesses have priority, bounded by a starvation limit, and a bus timeout.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_fetch,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t          state;
    logic [SW-1:0]   starve_cnt;
    logic [BW-1:0]   busy_cnt;
    logic            dm_any;
    logic            bubble;
    logic            fetch_win;
    logic            starved;
    logic            done;

    assign dm_any      = dm_rd | dm_wr;
    assign starved     = (starve_cnt == SW'(STARVE_LIMIT));
    assign fetch_win   = if_req & (~dm_any | starved);
    assign done        = mem_ready | (busy_cnt == BW'(TIMEOUT - 1));
    // The cycle a valid pulses carries a stale request level from the returning
    // requester; no grant is made then, so neither port wins the turnaround.
    assign bubble      = if_valid | dm_valid;
    assign stall_fetch = if_req & ~if_valid;
    assign stall_mem   = dm_any & ~dm_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            busy_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            bus_err    <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if (!if_req)
                starve_cnt <= '0;
            case (state)
                IDLE: begin
                    busy_cnt <= '0;
                    if (!bubble) begin
                        if (fetch_win) begin
                            state      <= BUSY_IF;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            starve_cnt <= '0;
                        end else if (dm_any) begin
                            state     <= BUSY_DM;
                            mem_req   <= 1'b1;
                            mem_we    <= dm_wr;  // rd+wr together is a store
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            if (if_req && !starved)
                                starve_cnt <= starve_cnt + SW'(1);
                        end
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (done) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        busy_cnt <= '0;
                        if (!mem_ready)
                            bus_err <= 1'b1;
                        if (state == BUSY_IF) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            dm_valid <= 1'b1;
                            if (!mem_we)
                                dm_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end else begin
                        busy_cnt <= busy_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of the arbiter followed by a randomized run against a
// transaction-level model (priority/starvation rule plus a memory array).
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SL = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, dm_rd, dm_wr, mem_ready;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic          if_valid, dm_valid, stall_fetch, stall_mem, mem_req, mem_we, bus_err;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_granted"}, {31'b0, mem_req}, 32'd1);
    endtask

    // model / scratch state
    logic [DW-1:0] mm [int];
    bit            if_pend, dm_pend, dm_we_m, dm_both, own_if, prev_req, got_fetch;
    logic [AW-1:0] ia, da, t_addr;
    logic [DW-1:0] dd, t_wd, exp_if, exp_dm;
    bit            t_we;
    int            dcnt, lat, wcnt, ndata, n;

    initial begin
        if_req = 0; if_addr = '0; dm_rd = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0;
        mem_ready = 0; mem_rdata = '0; reset = 1;
        step(); step();
        reset = 0;
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_flags", {28'b0, if_valid, dm_valid, bus_err, mem_we}, 0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 0);
        chk("rst_mem_wdata", {16'b0, mem_wdata}, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);

        // single fetch, minimum latency
        if_req = 1; if_addr = 16'h0004; #1;
        chk("f_stall_pre", {31'b0, stall_fetch}, 1);
        step();
        chk("f_req", {31'b0, mem_req}, 1);
        chk("f_addr", {16'b0, mem_addr}, 32'h0004);
        chk("f_we", {31'b0, mem_we}, 0);
        chk("f_stall_busy", {31'b0, stall_fetch}, 1);
        mem_ready = 1; mem_rdata = 16'h1234;
        step();
        mem_ready = 0;
        chk("f_valid", {31'b0, if_valid}, 1);
        chk("f_rdata", {16'b0, if_rdata}, 32'h1234);
        chk("f_stall_done", {31'b0, stall_fetch}, 0);
        chk("f_req_idle", {31'b0, mem_req}, 0);
        if_req = 0;
        step();
        chk("f_pulse_one", {31'b0, if_valid}, 0);
        chk("f_rdata_hold", {16'b0, if_rdata}, 32'h1234);

        // mem_ready while idle
        mem_ready = 1; mem_rdata = 16'hDEAD;
        step();
        mem_ready = 0;
        chk("idle_ready_ignored", {29'b0, mem_req, if_valid, dm_valid}, 0);
        chk("idle_rdata_hold", {16'b0, if_rdata}, 32'h1234);

        // store: registered fields hold while inputs move
        dm_wr = 1; dm_addr = 16'h0010; dm_wdata = 16'h00FF; #1;
        chk("w_stall_pre", {31'b0, stall_mem}, 1);
        step();
        chk("w_we", {31'b0, mem_we}, 1);
        chk("w_addr", {16'b0, mem_addr}, 32'h0010);
        chk("w_wdata", {16'b0, mem_wdata}, 32'h00FF);
        dm_addr = 16'h0020; dm_wdata = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("w_hold", {mem_req, mem_we, mem_addr, 14'b0}, {1'b1, 1'b1, 16'h0010, 14'b0});
            chk("w_hold_wdata", {16'b0, mem_wdata}, 32'h00FF);
        end
        mem_ready = 1; mem_rdata = 16'hBEEF;
        step();
        mem_ready = 0;
        chk("w_valid", {31'b0, dm_valid}, 1);
        chk("w_rdata_unchanged", {16'b0, dm_rdata}, 0);
        dm_wr = 0;
        step();

        // simultaneous fetch and load: data first
        if_req = 1; if_addr = 16'h0100; dm_rd = 1; dm_addr = 16'h0200;
        step();
        chk("pri_first_addr", {16'b0, mem_addr}, 32'h0200);
        chk("pri_first_we", {31'b0, mem_we}, 0);
        mem_ready = 1; mem_rdata = 16'h5555;
        step();
        mem_ready = 0;
        chk("pri_dm_valid", {31'b0, dm_valid}, 1);
        chk("pri_dm_rdata", {16'b0, dm_rdata}, 32'h5555);
        chk("pri_if_waiting", {30'b0, if_valid, stall_fetch}, 32'd1);
        dm_rd = 0;
        wait_req("pri_fetch");
        chk("pri_fetch_addr", {16'b0, mem_addr}, 32'h0100);
        chk("pri_fetch_we", {31'b0, mem_we}, 0);
        mem_ready = 1; mem_rdata = 16'h6666;
        step();
        mem_ready = 0;
        chk("pri_if_valid", {31'b0, if_valid}, 1);
        chk("pri_if_rdata", {16'b0, if_rdata}, 32'h6666);
        if_req = 0;
        step();

        // continuous stores against a waiting fetch
        if_req = 1; if_addr = 16'h0300; dm_wr = 1; dm_addr = 16'h0400; dm_wdata = 16'h0042;
        ndata = 0; got_fetch = 0;
        for (int k = 0; k < 8 && !got_fetch; k++) begin
            wait_req("starve");
            if (mem_addr == 16'h0300) got_fetch = 1;
            else ndata++;
            mem_ready = 1; mem_rdata = 16'h7000 + 16'(k);
            step();
            mem_ready = 0;
        end
        chk("starve_fetch_granted", {31'b0, got_fetch}, 1);
        chk("starve_data_grants", ndata, SL);
        if_req = 0; dm_wr = 0;
        step();

        // timeout
        if_req = 1; if_addr = 16'h0008;
        wait_req("to");
        n = 0;
        while (!if_valid && n < 40) begin
            step();
            n++;
        end
        chk("to_cycles", n, TO);
        chk("to_rdata", {16'b0, if_rdata}, 0);
        chk("to_err", {31'b0, bus_err}, 1);
        if_req = 0;
        repeat (3) step();
        chk("to_err_sticky", {31'b0, bus_err}, 1);
        chk("to_idle", {31'b0, mem_req}, 0);

        // reset during BUSY aborts silently
        reset = 1; step(); reset = 0;
        chk("rst2_err", {31'b0, bus_err}, 0);
        dm_rd = 1; dm_addr = 16'h0050;
        wait_req("abort");
        step();
        reset = 1; step(); reset = 0; dm_rd = 0;
        chk("abort_idle", {30'b0, mem_req, dm_valid}, 0);
        mem_ready = 1; mem_rdata = 16'h7777;
        step();
        mem_ready = 0;
        chk("abort_no_valid", {29'b0, mem_req, dm_valid, if_valid}, 0);
        step();
        chk("abort_rdata", {16'b0, dm_rdata}, 0);

        // randomized traffic against the transaction model
        if_pend = 0; dm_pend = 0; dcnt = 0; prev_req = 0; exp_if = '0; exp_dm = '0;
        own_if = 0; t_addr = '0; t_wd = '0; t_we = 0; lat = 0; wcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            mem_ready = 0;
            if (mem_req && !prev_req) begin
                own_if = if_pend && (!dm_pend || dcnt == SL);
                t_addr = own_if ? ia : da;
                t_we   = own_if ? 1'b0 : dm_we_m;
                t_wd   = dd;
                chk("rnd_grant_we", {31'b0, mem_we}, {31'b0, t_we});
                if (t_we) chk("rnd_grant_wdata", {16'b0, mem_wdata}, {16'b0, t_wd});
                if (own_if) dcnt = 0;
                else if (if_pend && dcnt < SL) dcnt++;
                lat = $urandom_range(0, 4);
                wcnt = 0;
            end
            if (mem_req) begin
                chk("rnd_mem_addr", {16'b0, mem_addr}, {16'b0, t_addr});
                if (wcnt == lat) begin
                    mem_ready = 1;
                    if (t_we) begin
                        mm[int'(t_addr)] = t_wd;
                        mem_rdata = 16'($urandom);
                    end else begin
                        mem_rdata = mm.exists(int'(t_addr)) ? mm[int'(t_addr)] : (t_addr ^ 16'h5A5A);
                        if (own_if) exp_if = mem_rdata;
                        else exp_dm = mem_rdata;
                    end
                end else begin
                    wcnt++;
                end
            end
            prev_req = mem_req;
            chk("rnd_stall_mem", {31'b0, stall_mem}, {31'b0, dm_pend && !dm_valid});
            if (if_valid || dm_valid)
                chk("rnd_valid_owner", {30'b0, if_valid, dm_valid}, own_if ? 32'd2 : 32'd1);
            if (if_valid) begin
                chk("rnd_if_rdata", {16'b0, if_rdata}, {16'b0, exp_if});
                if_pend = 0;
            end
            if (dm_valid) begin
                chk("rnd_dm_rdata", {16'b0, dm_rdata}, {16'b0, exp_dm});
                dm_pend = 0;
            end
            if (!if_pend && $urandom_range(0, 3) == 0) begin
                if_pend = 1;
                ia = {1'b0, 15'($urandom)};
            end
            if (!dm_pend && $urandom_range(0, 1) == 0) begin
                dm_pend = 1;
                dm_we_m = 1'($urandom_range(0, 1));
                dm_both = 1'($urandom_range(0, 1));
                da = {1'b1, 15'($urandom_range(0, 31))};
                dd = 16'($urandom);
            end
            if_req   = if_pend;
            if_addr  = ia;
            dm_rd    = dm_pend && (!dm_we_m || dm_both);
            dm_wr    = dm_pend && dm_we_m;
            dm_addr  = da;
            dm_wdata = dd;
        end
        chk("rnd_no_bus_err", {31'b0, bus_err}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
